cv_tdpram_be: RTL and testbench
===============================

Name: cv_tdpram_be

Overview:
- Single-clock true dual-port RAM with per-byte write enables and a selectable read-during-write mode: read-first or write-first.
- Deterministic cross-port collision resolution through internal forwarding; optional output pipeline register; per-port read-valid strobes.
- Next-generation shared buffer between datapath engines and the host-side register/DMA logic. Both ports run on one clock.

Parameters:
- D_WIDTH, 32, data width in bits; must be a multiple of 8.
- A_WIDTH, 10, address width; depth = 2**A_WIDTH words.
- RD_MODE, 0, read-during-write mode (0 = read-first, 1 = write-first); applies to same-port and cross-port collisions.
- OUT_REG, 0, extra output register stage (0 = read latency 1, 1 = read latency 2).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- addr0  in  A_WIDTH  port 0 address.
- ren0  in  1  port 0 read request.
- wen0  in  1  port 0 write request.
- be0  in  D_WIDTH/8  port 0 byte enables; bit i covers wrdata0[8i+7:8i].
- wrdata0  in  D_WIDTH  port 0 write data.
- rddata0  out  D_WIDTH  port 0 read data.
- rvalid0  out  1  port 0 read data valid, one-cycle pulse.
- addr1, ren1, wen1, be1, wrdata1, rddata1, rvalid1: port 1, identical to port 0.

Behaviour:
- Reset:
  - Synchronous, active-low. While rst_n=0: rddata0/1 = 0, rvalid0/1 = 0, all pipeline and forwarding registers = 0.
  - ren/wen are ignored; no memory write occurs.
  - Memory contents are not cleared and survive reset. Reset mid-read drops in-flight reads; no rvalid for them.
- Write:
  - wen=1 in cycle N writes only the lanes with be bit = 1 at addr. Other lanes keep their value.
  - wen=1 with be=0 is legal and is a no-op on memory.
  - The written value is visible to any read issued in cycle N+1 or later.
- Read:
  - ren=1 in cycle N: rvalid=1 and rddata valid in cycle N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
  - rddata holds its last value while rvalid=0; it updates only for a read.
  - Back-to-back reads every cycle give full throughput.
- Same-port read and write at the same address in one cycle (ren=wen=1):
  - RD_MODE=0: returns the pre-write word.
  - RD_MODE=1: returns the merged word (new lanes where be=1, old lanes elsewhere).
- Cross-port collision (port p reads address A while port q writes A in the same cycle):
  - RD_MODE=0: port p gets the pre-write word.
  - RD_MODE=1: port p gets the post-write merged word, supplied by the forwarding path. No undefined data is permitted.
- Write-write collision (both ports write address A in the same cycle):
  - Resolved per byte lane: where be0=1, port 0 data wins; where be0=0 and be1=1, port 1 data; otherwise the old value.
  - Write-first reads in that cycle return this resolved word.
- Addresses need no range checks: all 2**A_WIDTH locations are valid.

Decomposition:
- Shared package cv_ram_pkg holds:
  - constants RD_FIRST=0 and WR_FIRST=1;
  - a function that merges old data, new data and byte enables;
  - an elaboration-time check that D_WIDTH%8==0 and RD_MODE is in {0,1}.
- One sub-module, cv_ram_rdpipe:
  - per-port output stage (collision mux select, optional OUT_REG register, rvalid shift), instantiated twice;
  - parameters D_WIDTH and OUT_REG.

Test Plan:
- Reset holds outputs: rst_n=0 for 3 cycles with ren0=ren1=1 → rvalid0/1=0 and rddata0/1=0 throughout. A prior write of 0xDEADBEEF to addr 5, read after release → 0xDEADBEEF.
- Byte-enable write: write 0x11223344 to addr 3, then port1 writes 0xAABBCCDD with be1=4'b0101 → port0 read of addr 3 returns 0x11BB33DD, latency 1 (OUT_REG=0) and latency 2 (OUT_REG=1).
- Same-port RAW, mem[7]=0x00000000, port0 ren=wen=1, wrdata 0x12345678, be=4'hF → RD_MODE=0 returns 0x00000000; RD_MODE=1 returns 0x12345678. The next read returns 0x12345678 in both modes.
- Cross-port collision, mem[9]=0xCAFEF00D: port1 writes 0x0000BEEF be=4'b0011 while port0 reads 9 → RD_MODE=0: 0xCAFEF00D; RD_MODE=1: 0xCAFEBEEF.
- Write-write, mem[2]=0: port0 writes 0xAAAAAAAA be0=4'b1100, port1 writes 0x55555555 be1=4'b0110 → mem[2]=0xAAAA5500 on subsequent read.
- Streaming with reset abort: ren0 on addr 0..15 each cycle, rst_n=0 at the 8th cycle → rvalid drops the cycle after; no rvalid for aborted reads; mem contents intact on re-read.

Source files
------------

// File: rtl/cv_ram_pkg.sv
// Shared constants and helpers for the cv_* RAM family.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cv_ram_pkg;

    // Read-during-write policies.
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Byte-lane merge: take the new byte where the lane enable is set, keep the old one otherwise.
    function automatic logic [7:0] merge_lane(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       en
    );
        return en ? new_b : old_b;
    endfunction

    // Legal configurations: whole bytes only, and a known read-during-write policy.
    function automatic bit cfg_ok(input int d_width, input int rd_mode);
        return (d_width > 0) && ((d_width % 8) == 0) &&
               ((rd_mode == RD_FIRST) || (rd_mode == WR_FIRST));
    endfunction

endpackage

// File: rtl/cv_ram_rdpipe.sv
// Per-port read output stage: collision select, optional output register, valid strobe.
// Latency: 1 cycle from ren (OUT_REG=0) or 2 cycles (OUT_REG=1).
// Backpressure: none; accepts a read every cycle, data holds between valid pulses.
module cv_ram_rdpipe #(
    parameter int D_WIDTH = 32,
    parameter int OUT_REG = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ren,
    input  logic [D_WIDTH-1:0] ram_dat,
    input  logic [D_WIDTH-1:0] fwd_dat,
    input  logic               fwd_sel,
    output logic [D_WIDTH-1:0] rddata,
    output logic               rvalid
);

    logic [D_WIDTH-1:0] s1_dat;
    logic               s1_vld;

    // First stage: capture either the array word or the forwarded collision word, only on a read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_dat <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= ren;
            if (ren) begin
                s1_dat <= fwd_sel ? fwd_dat : ram_dat;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [D_WIDTH-1:0] s2_dat;
        logic               s2_vld;

        // Optional second stage: moves only when stage one carries a valid read, so data holds otherwise.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s2_dat <= '0;
                s2_vld <= 1'b0;
            end else begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_dat <= s1_dat;
                end
            end
        end

        assign rddata = s2_dat;
        assign rvalid = s2_vld;
    end else begin : g_noreg
        assign rddata = s1_dat;
        assign rvalid = s1_vld;
    end

endmodule

// File: rtl/cv_tdpram_be.sv
// True dual-port RAM, single clock, byte enables, read-first or write-first collisions.
// Latency: read data and rvalid 1 cycle after ren (OUT_REG=0) or 2 cycles (OUT_REG=1).
// Backpressure: none; both ports accept a read and/or write every cycle.
module cv_tdpram_be
    import cv_ram_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 10,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [A_WIDTH-1:0]   addr0,
    input  logic                 ren0,
    input  logic                 wen0,
    input  logic [D_WIDTH/8-1:0] be0,
    input  logic [D_WIDTH-1:0]   wrdata0,
    output logic [D_WIDTH-1:0]   rddata0,
    output logic                 rvalid0,
    input  logic [A_WIDTH-1:0]   addr1,
    input  logic                 ren1,
    input  logic                 wen1,
    input  logic [D_WIDTH/8-1:0] be1,
    input  logic [D_WIDTH-1:0]   wrdata1,
    output logic [D_WIDTH-1:0]   rddata1,
    output logic                 rvalid1
);

    localparam int NB    = D_WIDTH / 8;
    localparam int DEPTH = 1 << A_WIDTH;

    if (!cfg_ok(D_WIDTH, RD_MODE)) begin : g_cfg_err
        $error("cv_tdpram_be: D_WIDTH must be a multiple of 8 and RD_MODE must be 0 or 1");
    end

    logic [D_WIDTH-1:0] mem [DEPTH];

    logic [D_WIDTH-1:0] old0;
    logic [D_WIDTH-1:0] old1;
    logic [D_WIDTH-1:0] fwd0;
    logic [D_WIDTH-1:0] fwd1;
    logic               same_addr;
    logic               hit0;
    logic               hit1;
    logic               fwd_sel0;
    logic               fwd_sel1;

    // Pre-write words and the post-write merged words each port would see this cycle.
    // Port 1 is applied first and port 0 last, so port 0 owns contested lanes.
    always_comb begin
        old0      = mem[addr0];
        old1      = mem[addr1];
        same_addr = (addr0 == addr1);
        fwd0      = old0;
        fwd1      = old1;
        for (int b = 0; b < NB; b++) begin
            fwd0[8*b +: 8] = merge_lane(fwd0[8*b +: 8], wrdata1[8*b +: 8], wen1 && same_addr && be1[b]);
            fwd0[8*b +: 8] = merge_lane(fwd0[8*b +: 8], wrdata0[8*b +: 8], wen0 && be0[b]);
            fwd1[8*b +: 8] = merge_lane(fwd1[8*b +: 8], wrdata1[8*b +: 8], wen1 && be1[b]);
            fwd1[8*b +: 8] = merge_lane(fwd1[8*b +: 8], wrdata0[8*b +: 8], wen0 && same_addr && be0[b]);
        end
        hit0     = wen0 || (wen1 && same_addr);
        hit1     = wen1 || (wen0 && same_addr);
        fwd_sel0 = (RD_MODE == WR_FIRST) && hit0;
        fwd_sel1 = (RD_MODE == WR_FIRST) && hit1;
    end

    // Array writes, per lane; port 0 is written last so it wins a same-address, same-lane contest.
    // Gated by rst_n so nothing is written while in reset; contents are otherwise never cleared.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int b = 0; b < NB; b++) begin
                if (wen1 && be1[b]) begin
                    mem[addr1][8*b +: 8] <= wrdata1[8*b +: 8];
                end
                if (wen0 && be0[b]) begin
                    mem[addr0][8*b +: 8] <= wrdata0[8*b +: 8];
                end
            end
        end
    end

    cv_ram_rdpipe #(
        .D_WIDTH (D_WIDTH),
        .OUT_REG (OUT_REG)
    ) u_rdpipe0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ren     (ren0),
        .ram_dat (old0),
        .fwd_dat (fwd0),
        .fwd_sel (fwd_sel0),
        .rddata  (rddata0),
        .rvalid  (rvalid0)
    );

    cv_ram_rdpipe #(
        .D_WIDTH (D_WIDTH),
        .OUT_REG (OUT_REG)
    ) u_rdpipe1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ren     (ren1),
        .ram_dat (old1),
        .fwd_dat (fwd1),
        .fwd_sel (fwd_sel1),
        .rddata  (rddata1),
        .rvalid  (rvalid1)
    );

endmodule

// File: tb/tb_cv_tdpram_be.sv
// Bench for cv_tdpram_be: four instances cover read-first/write-first x OUT_REG 0/1.
// Latency: n/a.
// Backpressure: n/a.
module tb_cv_tdpram_be;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NB    = DW / 8;
    localparam int NI    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n   = 1'b0;
    logic [AW-1:0] addr0   = '0;
    logic [AW-1:0] addr1   = '0;
    logic          ren0    = 1'b0;
    logic          ren1    = 1'b0;
    logic          wen0    = 1'b0;
    logic          wen1    = 1'b0;
    logic [NB-1:0] be0     = '0;
    logic [NB-1:0] be1     = '0;
    logic [DW-1:0] wrdata0 = '0;
    logic [DW-1:0] wrdata1 = '0;

    logic [NI-1:0][DW-1:0] rd0;
    logic [NI-1:0][DW-1:0] rd1;
    logic [NI-1:0]         rv0;
    logic [NI-1:0]         rv1;

    // Instance g: RD_MODE = g%2, OUT_REG = g/2.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        cv_tdpram_be #(
            .D_WIDTH (DW),
            .A_WIDTH (AW),
            .RD_MODE (g % 2),
            .OUT_REG (g / 2)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .addr0   (addr0),
            .ren0    (ren0),
            .wen0    (wen0),
            .be0     (be0),
            .wrdata0 (wrdata0),
            .rddata0 (rd0[g]),
            .rvalid0 (rv0[g]),
            .addr1   (addr1),
            .ren1    (ren1),
            .wen1    (wen1),
            .be1     (be1),
            .wrdata1 (wrdata1),
            .rddata1 (rd1[g]),
            .rvalid1 (rv1[g])
        );
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: plain word array plus, per instance/port, a queue of reads with the cycle they are due.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0] mdl [DEPTH];
    rd_t           pq [2*NI][$];
    logic          exp_v [2*NI];
    logic [DW-1:0] exp_d [2*NI];
    logic [DW-1:0] obs0 [NI][$];
    logic [DW-1:0] obs1 [NI][$];
    int            vcnt0 [NI];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] w, input logic [DW-1:0] d,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Word a port sees this cycle: the stored word, or with write-first the word after this cycle's writes.
    function automatic logic [DW-1:0] seen(input logic [AW-1:0] a, input bit wf);
        logic [DW-1:0] w;
        w = mdl[a];
        if (wf) begin
            if (wen1 && addr1 == a) w = merge(w, wrdata1, be1);
            if (wen0 && addr0 == a) w = merge(w, wrdata0, be0);
        end
        return w;
    endfunction

    task automatic idle();
        ren0 = 1'b0; ren1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
        be0  = '0;   be1  = '0;
    endtask

    // Advance one clock, update the model with the inputs seen at the edge, then observe outputs 1 time unit later.
    task automatic tick();
        rd_t r;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            for (int k = 0; k < 2*NI; k++) begin
                pq[k].delete();
                exp_d[k] = '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (ren0) begin
                    r.due = cyc + i/2; r.d = seen(addr0, (i % 2) == 1);
                    pq[2*i].push_back(r);
                end
                if (ren1) begin
                    r.due = cyc + i/2; r.d = seen(addr1, (i % 2) == 1);
                    pq[2*i+1].push_back(r);
                end
            end
            if (wen1) mdl[addr1] = merge(mdl[addr1], wrdata1, be1);
            if (wen0) mdl[addr0] = merge(mdl[addr0], wrdata0, be0);
        end
        #1;
        for (int k = 0; k < 2*NI; k++) begin
            if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
                exp_v[k] = 1'b1;
                exp_d[k] = pq[k][0].d;
                void'(pq[k].pop_front());
            end else begin
                exp_v[k] = 1'b0;
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (rv0[i] === 1'b1) begin obs0[i].push_back(rd0[i]); vcnt0[i]++; end
            if (rv1[i] === 1'b1) obs1[i].push_back(rd1[i]);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NI; i++) begin
            obs0[i].delete(); obs1[i].delete(); vcnt0[i] = 0;
        end
    endtask

    task automatic init_fill();
        rst_n = 1'b0; idle();
        tick(); tick();
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH/2; a++) begin
            addr0 = AW'(2*a);   wen0 = 1'b1; be0 = '1; wrdata0 = $urandom;
            addr1 = AW'(2*a+1); wen1 = 1'b1; be1 = '1; wrdata1 = $urandom;
            tick();
        end
        idle();
        addr0 = 5; wen0 = 1'b1; be0 = '1; wrdata0 = 32'hDEADBEEF;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ren0 = 1'b1; ren1 = 1'b1; addr0 = 5; addr1 = 5;
        wen0 = 1'b1; be0 = '1; wrdata0 = 32'h0BAD0BAD;
        repeat (3) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (rv0[i] !== 1'b0 || rv1[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_rvalid inst%0d got %b/%b exp 0/0", i, rv0[i], rv1[i]);
                end
                vectors++;
                if (rd0[i] !== '0 || rd1[i] !== '0) begin
                    miscompares++;
                    $display("FAIL reset_rddata inst%0d got %h/%h exp 0/0", i, rd0[i], rd1[i]);
                end
            end
        end
        idle();
        rst_n = 1'b1;
        clear_obs();
        ren0 = 1'b1; addr0 = 5;
        tick(); idle(); tick();
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (obs0[i].size() != 1 || obs0[i][0] !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL reset_keep inst%0d got %0d reads first %h exp 1 read DEADBEEF",
                         i, obs0[i].size(), (obs0[i].size() > 0) ? obs0[i][0] : 32'h0);
            end
        end
    endtask

    task automatic test_byte_enable();
        idle();
        addr0 = 3; wen0 = 1'b1; be0 = '1; wrdata0 = 32'h11223344;
        tick(); idle();
        addr1 = 3; wen1 = 1'b1; be1 = 4'b0101; wrdata1 = 32'hAABBCCDD;
        tick(); idle();
        clear_obs();
        addr0 = 3; ren0 = 1'b1;
        tick(); idle();
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (rv0[i] !== ((i / 2) == 0)) begin
                miscompares++;
                $display("FAIL be_lat_first inst%0d rvalid got %b exp %b", i, rv0[i], (i / 2) == 0);
            end
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (rv0[i] !== ((i / 2) == 1)) begin
                miscompares++;
                $display("FAIL be_lat_second inst%0d rvalid got %b exp %b", i, rv0[i], (i / 2) == 1);
            end
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (obs0[i].size() != 1 || obs0[i][0] !== 32'h11BB33DD) begin
                miscompares++;
                $display("FAIL be_merge inst%0d got %0d reads first %h exp 11BB33DD",
                         i, obs0[i].size(), (obs0[i].size() > 0) ? obs0[i][0] : 32'h0);
            end
        end
    endtask

    task automatic test_same_port_raw();
        logic [DW-1:0] e;
        idle();
        addr0 = 7; wen0 = 1'b1; be0 = '1; wrdata0 = 32'h0;
        tick(); idle();
        clear_obs();
        addr0 = 7; ren0 = 1'b1; wen0 = 1'b1; be0 = '1; wrdata0 = 32'h12345678;
        tick(); idle();
        addr0 = 7; ren0 = 1'b1;
        tick(); idle(); tick(); tick();
        for (int i = 0; i < NI; i++) begin
            e = (i % 2 == 1) ? 32'h12345678 : 32'h0;
            vectors++;
            if (obs0[i].size() != 2 || obs0[i][0] !== e || obs0[i][1] !== 32'h12345678) begin
                miscompares++;
                $display("FAIL same_port_raw inst%0d got %0d reads %h,%h exp %h,12345678", i,
                         obs0[i].size(), (obs0[i].size() > 0) ? obs0[i][0] : 32'h0,
                         (obs0[i].size() > 1) ? obs0[i][1] : 32'h0, e);
            end
        end
    endtask

    task automatic test_cross_port();
        logic [DW-1:0] e;
        idle();
        addr0 = 9; wen0 = 1'b1; be0 = '1; wrdata0 = 32'hCAFEF00D;
        tick(); idle();
        clear_obs();
        addr0 = 9; ren0 = 1'b1;
        addr1 = 9; wen1 = 1'b1; be1 = 4'b0011; wrdata1 = 32'h0000BEEF;
        tick(); idle();
        addr0 = 9; ren0 = 1'b1;
        tick(); idle(); tick(); tick();
        for (int i = 0; i < NI; i++) begin
            e = (i % 2 == 1) ? 32'hCAFEBEEF : 32'hCAFEF00D;
            vectors++;
            if (obs0[i].size() != 2 || obs0[i][0] !== e || obs0[i][1] !== 32'hCAFEBEEF) begin
                miscompares++;
                $display("FAIL cross_port inst%0d got %0d reads %h,%h exp %h,CAFEBEEF", i,
                         obs0[i].size(), (obs0[i].size() > 0) ? obs0[i][0] : 32'h0,
                         (obs0[i].size() > 1) ? obs0[i][1] : 32'h0, e);
            end
        end
    endtask

    task automatic test_write_write();
        logic [DW-1:0] e;
        idle();
        addr0 = 2; wen0 = 1'b1; be0 = '1; wrdata0 = 32'h0;
        tick(); idle();
        clear_obs();
        addr0 = 2; wen0 = 1'b1; be0 = 4'b1100; wrdata0 = 32'hAAAAAAAA;
        addr1 = 2; wen1 = 1'b1; be1 = 4'b0110; wrdata1 = 32'h55555555; ren1 = 1'b1;
        tick(); idle();
        addr0 = 2; ren0 = 1'b1;
        tick(); idle(); tick(); tick();
        for (int i = 0; i < NI; i++) begin
            e = (i % 2 == 1) ? 32'hAAAA5500 : 32'h0;
            vectors++;
            if (obs1[i].size() != 1 || obs1[i][0] !== e) begin
                miscompares++;
                $display("FAIL ww_collide_read inst%0d got %0d reads first %h exp %h", i,
                         obs1[i].size(), (obs1[i].size() > 0) ? obs1[i][0] : 32'h0, e);
            end
            vectors++;
            if (obs0[i].size() != 1 || obs0[i][0] !== 32'hAAAA5500) begin
                miscompares++;
                $display("FAIL ww_result inst%0d got %0d reads first %h exp AAAA5500", i,
                         obs0[i].size(), (obs0[i].size() > 0) ? obs0[i][0] : 32'h0);
            end
        end
    endtask

    task automatic test_stream_reset();
        logic          gv;
        logic [DW-1:0] gd;
        idle();
        clear_obs();
        for (int j = 0; j < 2*16 + 4; j++) begin
            idle();
            rst_n = 1'b1;
            if (j < 16) begin
                addr0 = AW'(j); ren0 = 1'b1;
                rst_n = !(j == 7 || j == 8);
            end else if (j >= 18 && j < 34) begin
                addr0 = AW'(j - 18); ren0 = 1'b1;
                addr1 = AW'(33 - j); ren1 = 1'b1;
            end
            tick();
            if (j == 7) begin
                for (int i = 0; i < NI; i++) begin
                    vectors++;
                    if (rv0[i] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL stream_abort inst%0d rvalid got %b exp 0", i, rv0[i]);
                    end
                end
            end
            if (j == 17) begin
                for (int i = 0; i < NI; i++) begin
                    vectors++;
                    if (vcnt0[i] != ((i / 2 == 1) ? 13 : 14)) begin
                        miscompares++;
                        $display("FAIL stream_count inst%0d got %0d exp %0d", i, vcnt0[i],
                                 (i / 2 == 1) ? 13 : 14);
                    end
                end
            end
            for (int k = 0; k < 2*NI; k++) begin
                gv = (k % 2 == 1) ? rv1[k/2] : rv0[k/2];
                gd = (k % 2 == 1) ? rd1[k/2] : rd0[k/2];
                vectors++;
                if (gv !== exp_v[k]) begin
                    miscompares++;
                    $display("FAIL stream_rvalid cyc%0d inst%0d port%0d got %b exp %b", cyc, k/2, k%2, gv, exp_v[k]);
                end
                vectors++;
                if (gd !== exp_d[k]) begin
                    miscompares++;
                    $display("FAIL stream_rddata cyc%0d inst%0d port%0d got %h exp %h", cyc, k/2, k%2, gd, exp_d[k]);
                end
            end
        end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic          gv;
        logic [DW-1:0] gd;
        for (int n = 0; n < 500; n++) begin
            rst_n   = ($urandom_range(0, 60) != 0);
            addr0   = AW'($urandom_range(0, 3));
            addr1   = AW'($urandom_range(0, 3));
            ren0    = $urandom_range(0, 1) == 1;
            ren1    = $urandom_range(0, 1) == 1;
            wen0    = $urandom_range(0, 1) == 1;
            wen1    = $urandom_range(0, 1) == 1;
            be0     = NB'($urandom);
            be1     = NB'($urandom);
            wrdata0 = $urandom;
            wrdata1 = $urandom;
            tick();
            for (int k = 0; k < 2*NI; k++) begin
                gv = (k % 2 == 1) ? rv1[k/2] : rv0[k/2];
                gd = (k % 2 == 1) ? rd1[k/2] : rd0[k/2];
                vectors++;
                if (gv !== exp_v[k]) begin
                    miscompares++;
                    $display("FAIL rand_rvalid cyc%0d inst%0d port%0d got %b exp %b", cyc, k/2, k%2, gv, exp_v[k]);
                end
                vectors++;
                if (gd !== exp_d[k]) begin
                    miscompares++;
                    $display("FAIL rand_rddata cyc%0d inst%0d port%0d got %h exp %h", cyc, k/2, k%2, gd, exp_d[k]);
                end
            end
        end
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        init_fill();
        test_reset();
        test_byte_enable();
        test_same_port_raw();
        test_cross_port();
        test_write_write();
        test_stream_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, got cyc %0d exp < 100000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
